// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_loader
// Purpose  : Programs the fir coefficient bank through its control-register
//            port while holding the MAC chain stalled, then flushes it.
// Revision : 1.0
// ============================================================================
module fir_coeff_loader #(
    parameter int         TAP       = 32,
    parameter int         LOG2TAP   = 5,
    parameter int         DIM_COEFF = 16,
    parameter int         WR_GAP    = 2,
    parameter logic [3:0] OP_CLR    = 4'h1,
    parameter logic [3:0] OP_STO    = 4'h2,
    parameter logic [3:0] OP_NOP    = 4'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 ext_stall,
    input  logic                 coeff_valid,
    input  logic [DIM_COEFF-1:0] coeff_data,
    output logic                 coeff_ready,
    output logic                 fir_we,
    output logic [31:0]          fir_cr,
    output logic                 fir_stall,
    output logic                 fir_clr,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLR_WR = 3'd1;
    localparam logic [2:0] c_GAP    = 3'd2;
    localparam logic [2:0] c_LOAD   = 3'd3;
    localparam logic [2:0] c_STO_WR = 3'd4;
    localparam logic [2:0] c_NOP_WR = 3'd5;
    localparam logic [2:0] c_FLUSH  = 3'd6;

    localparam int                 c_GAP_W    = (WR_GAP < 2) ? 1 : $clog2(WR_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(WR_GAP - 1);
    localparam logic [LOG2TAP-1:0] c_IDX_LAST = LOG2TAP'(TAP - 1);

    logic [2:0]         r_state, w_state_nxt;
    logic [2:0]         r_ret,   w_ret_nxt;
    logic [LOG2TAP-1:0] r_idx,   w_idx_nxt;
    logic [c_GAP_W-1:0] r_gap,   w_gap_nxt;
    logic               r_inc,   w_inc_nxt;
    logic [31:0]        r_cr,    w_cr_nxt;
    logic               r_done,  w_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ret   <= c_IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
            r_inc   <= 1'b0;
            r_cr    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_inc   <= w_inc_nxt;
            r_cr    <= w_cr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The control word is loaded on the edge that enters a write state, so
    // fir_cr is valid exactly in the cycle fir_we is decoded high.
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_inc_nxt   = r_inc;
        w_cr_nxt    = r_cr;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_CLR_WR;
                    w_cr_nxt    = {16'h0, 8'h0, OP_CLR, 4'h0};
                end
            end
            c_CLR_WR: begin
                w_idx_nxt   = '0;
                w_inc_nxt   = 1'b0;
                w_ret_nxt   = c_LOAD;
                w_gap_nxt   = '0;
                w_state_nxt = c_GAP;
            end
            c_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = r_ret;
                    w_gap_nxt   = '0;
                    w_inc_nxt   = 1'b0;
                    if (r_inc) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                    if (r_ret == c_NOP_WR) begin
                        w_cr_nxt = {16'h0, 8'h0, OP_NOP, 4'h0};
                    end
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            c_LOAD: begin
                if (coeff_valid) begin
                    w_state_nxt = c_STO_WR;
                    w_cr_nxt    = {16'(coeff_data), 8'(r_idx), OP_STO, 4'h0};
                end
            end
            c_STO_WR: begin
                w_state_nxt = c_GAP;
                w_gap_nxt   = '0;
                if (r_idx == c_IDX_LAST) begin
                    w_ret_nxt = c_NOP_WR;
                    w_inc_nxt = 1'b0;
                end else begin
                    w_ret_nxt = c_LOAD;
                    w_inc_nxt = 1'b1;
                end
            end
            c_NOP_WR: begin
                w_state_nxt = c_GAP;
                w_gap_nxt   = '0;
                w_ret_nxt   = c_FLUSH;
            end
            c_FLUSH: begin
                w_state_nxt = c_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != c_IDLE);
    assign coeff_ready = (r_state == c_LOAD);
    assign fir_we      = (r_state == c_CLR_WR) || (r_state == c_STO_WR) ||
                         (r_state == c_NOP_WR);
    assign fir_clr     = (r_state == c_FLUSH);
    assign fir_stall   = busy | ext_stall;
    assign fir_cr      = r_cr;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_loader
// Purpose  : Randomized scoreboard bench for fir_coeff_loader.
// Revision : 1.0
// ============================================================================
module tb_fir_coeff_loader;

    localparam int TAP     = 32;
    localparam int LOG2TAP = 5;
    localparam int DIM     = 16;
    localparam int WR_GAP  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            ext_stall = 1'b0;
    logic            coeff_valid = 1'b0;
    logic [DIM-1:0]  coeff_data = '0;
    logic            coeff_ready, fir_we, fir_stall, fir_clr, busy, done;
    logic [31:0]     fir_cr;

    fir_coeff_loader #(
        .TAP(TAP), .LOG2TAP(LOG2TAP), .DIM_COEFF(DIM), .WR_GAP(WR_GAP),
        .OP_CLR(4'h1), .OP_STO(4'h2), .OP_NOP(4'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ext_stall(ext_stall),
        .coeff_valid(coeff_valid), .coeff_data(coeff_data),
        .coeff_ready(coeff_ready), .fir_we(fir_we), .fir_cr(fir_cr),
        .fir_stall(fir_stall), .fir_clr(fir_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          last_we = -100;
    int          done_cnt = 0;
    int          clr_cnt = 0;
    logic [15:0] cur_c[TAP];
    int          idle_arr[TAP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Upstream stall wanders randomly, changing away from the sampling edge.
    initial begin
        forever begin
            @(posedge clk);
            #2 ext_stall = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every write and watches stall/spacing.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_we = -100;
            check("reset_outputs", {27'h0, busy, done, fir_we, fir_clr, coeff_ready}, 32'h0);
            check("reset_cr", fir_cr, 32'h0);
            check("reset_stall", {31'h0, fir_stall}, {31'h0, ext_stall});
        end else begin
            cyc++;
            if (busy) check("stall_busy", {31'h0, fir_stall}, 32'h1);
            else      check("stall_idle", {31'h0, fir_stall}, {31'h0, ext_stall});
            if (fir_we) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                    $display("  write word 0x%08h", fir_cr);
                end else begin
                    check("write_word", fir_cr, exp_q.pop_front());
                end
                check("write_spacing", {31'h0, (cyc - last_we) > WR_GAP}, 32'h1);
                last_we = cyc;
            end
            if (done)    done_cnt++;
            if (fir_clr) clr_cnt++;
        end
    end

    task automatic source();
        for (int i = 0; i < TAP; i++) begin
            int n;
            coeff_data  = cur_c[i];
            coeff_valid = (idle_arr[i] == 0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!coeff_ready && n < 1000);
            if (!coeff_ready) begin
                fail_now("load_timeout");
                coeff_valid = 1'b0;
                return;
            end
            repeat (idle_arr[i]) begin
                @(negedge clk);
                check("bp_ready", {31'h0, coeff_ready}, 32'h1);
                check("bp_no_write", {31'h0, fir_we}, 32'h0);
            end
            coeff_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        coeff_valid = 1'b0;
    endtask

    task automatic run_load(input bit inc_coeffs, input int drop_tap, input int drop_len,
                            input bit rnd, input bit spurious);
        int exp_len;
        int d0;
        int c0;
        int k;
        int busy_cnt;
        int clr_k;
        exp_len  = 1 + WR_GAP + TAP * (2 + WR_GAP) + 1 + WR_GAP + 1;
        d0       = done_cnt;
        c0       = clr_cnt;
        k        = 0;
        busy_cnt = 0;
        clr_k    = -1;
        for (int i = 0; i < TAP; i++) begin
            cur_c[i]    = inc_coeffs ? 16'(16'h0100 + i) : 16'($urandom);
            idle_arr[i] = (i == drop_tap) ? drop_len : (rnd ? $urandom_range(0, 3) : 0);
            exp_len    += idle_arr[i];
        end
        exp_q.push_back(32'h0000_0010);
        for (int i = 0; i < TAP; i++) exp_q.push_back({cur_c[i], 8'(i), 4'h2, 4'h0});
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        start = 1'b1;
        fork
            source();
            begin
                while (k < 5000) begin
                    @(negedge clk);
                    if (k == 0) start = 1'b0;
                    k++;
                    if (busy) busy_cnt++;
                    if (fir_clr) clr_k = k;
                    if (done) break;
                end
            end
            begin
                if (spurious) begin
                    repeat (40) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        @(negedge clk);
        #1;
        check("done_cycle", k, exp_len + 1);
        check("busy_cycles", busy_cnt, exp_len);
        check("clr_cycle", clr_k, exp_len);
        check("done_pulses", done_cnt - d0, 1);
        check("clr_pulses", clr_cnt - c0, 1);
        check("writes_left", exp_q.size(), 0);
    endtask

    task automatic abort_test();
        int n;
        bit found;
        n     = 0;
        found = 1'b0;
        exp_q.push_back(32'h0000_0010);
        for (int i = 0; i < TAP; i++) exp_q.push_back({16'hA5A5, 8'(i), 4'h2, 4'h0});
        coeff_data  = 16'hA5A5;
        coeff_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        while (n < 2000 && !found) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (fir_we && fir_cr[15:8] == 8'd10 && fir_cr[7:4] == 4'h2) found = 1'b1;
        end
        check("abort_reached_tap10", {31'h0, found}, 32'h1);
        @(negedge clk);
        check("abort_in_gap", {30'h0, busy, fir_we}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("async_outputs", {27'h0, busy, done, fir_we, fir_clr, coeff_ready}, 32'h0);
        check("async_cr", fir_cr, 32'h0);
        check("async_stall", {31'h0, fir_stall}, {31'h0, ext_stall});
        coeff_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {27'h0, busy, done, fir_we, fir_clr, coeff_ready}, 32'h0);
            check("idle_cr", fir_cr, 32'h0);
        end
        run_load(1'b1, -1, 0, 1'b0, 1'b0);
        run_load(1'b0,  5, 7, 1'b0, 1'b0);
        run_load(1'b0, -1, 0, 1'b1, 1'b1);
        abort_test();
        run_load(1'b1, -1, 0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Sequencer that programs the coefficient bank of the `fir` datapath through its 32-bit control-register port and keeps the MAC chain frozen and flushed while it does so. It sits between the host/coefficient source, which streams coefficients over a valid/ready handshake, and the `fir` instance. It issues the clear, per-tap store and disarm control words with the required spacing. After loading, it clears the accumulators and releases the stall.

## Interface
- `TAP`, 32: number of taps; must match the `fir` instance, 2..256.
- `LOG2TAP`, 5: tap index width, ceil(log2(TAP)).
- `DIM_COEFF`, 16: coefficient width; must be ≤16.
- `WR_GAP`, 2: idle cycles after each control-word write, ≥1, so `fir` can register and decode the word.
- `OP_CLR`, 4'h1: opcode for clearing all coefficients.
- `OP_STO`, 4'h2: opcode for storing one coefficient.
- `OP_NOP`, 4'h0: opcode for idle/disarm.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a reload; sampled only in IDLE.
- `ext_stall` in 1: upstream stall request, ORed into `fir_stall`.
- `coeff_valid` in 1: coefficient source has data.
- `coeff_data` in DIM_COEFF: coefficient; taps are loaded in index order 0..TAP-1.
- `coeff_ready` out 1: loader accepts `coeff_data` this cycle.
- `fir_we` out 1: drives `fir.we_in`.
- `fir_cr` out 32: drives `fir.cr_in`.
- `fir_stall` out 1: drives `fir.stall`.
- `fir_clr` out 1: drives `fir.clr`.
- `busy` out 1: reload in progress.
- `done` out 1: one-cycle pulse when a reload completes.

## Operation
- Control word format: `[31:16]` coefficient (zero-extended from DIM_COEFF), `[15:8]` tap index (zero-extended from LOG2TAP), `[7:4]` opcode, `[3:0]` = 0.
- `fir_cr` is held at its last written value between writes. It is only meaningful while `fir_we`=1.
- FSM states and transitions:
  - IDLE: waits for `start`, then goes to CLR_WR.
  - CLR_WR: writes `{16'h0, 8'h0, OP_CLR, 4'h0}`, then goes to GAP.
  - GAP: counts WR_GAP cycles, then goes to the return state. The return state is LOAD after CLR_WR, LOAD after a store when index<TAP-1, NOP_WR after the last store, and FLUSH after NOP_WR.
  - LOAD: `coeff_ready`=1. When `coeff_valid` is high, captures `coeff_data` and goes to STO_WR. Otherwise stays in LOAD with no timeout.
  - STO_WR: writes `{coeff, idx, OP_STO, 4'h0}`, then goes to GAP. The index increments on leaving GAP.
  - NOP_WR: writes `{16'h0, 8'h0, OP_NOP, 4'h0}`, then goes to GAP.
  - FLUSH: `fir_clr`=1 for exactly one cycle, then goes to IDLE with `done`=1.
- `busy` is 1 in every state except IDLE.
- `fir_stall = busy | ext_stall`. The MACs are frozen for the whole reload, including the FLUSH cycle.
- `coeff_ready` is a registered-state decode, with no combinational path from `coeff_valid`.
- `start` while busy is ignored and is not queued.
- The tap index is LOG2TAP bits wide, resets to 0, and resets to 0 at each CLR_WR. The final store is detected when index == TAP-1. The index never wraps past TAP-1.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - state IDLE, index 0, GAP counter 0.
  - `fir_cr`=0, `fir_we`=0, `fir_clr`=0, `coeff_ready`=0, `busy`=0, `done`=0.
  - `fir_stall`=`ext_stall` (combinational OR; only `busy` is reset).
- Reset mid-reload: aborts immediately. No further `fir_we`. A partial coefficient load remains in `fir`, and the next `start` performs a full clear.
- Write timing:
  - `start` high at edge N: CLR_WR, `fir_we`=1 in cycle N+1.
  - First LOAD is in cycle N+2+WR_GAP.
  - Each STO_WR occurs in the cycle after the accepting LOAD cycle.
- Reload length with `coeff_valid` held high: 1 + WR_GAP + TAP·(2+WR_GAP) + 1 + WR_GAP + 1 cycles of `busy`. This is 135 for the defaults.
- `done` is high in the first IDLE cycle after FLUSH. `busy` is 0 in that cycle, and a new `start` is accepted in that same cycle.
- `fir_we` is never high in two consecutive cycles. At least WR_GAP cycles separate writes.

## Test plan
- Reset/idle: hold `rst_n` low, then release with no `start` → all outputs 0, `fir_stall` follows `ext_stall` for 20 cycles.
- Full load (defaults), coefficients 0x0100+i, `coeff_valid` always high → 34 writes:
  - CLR word 0x00000010;
  - STO words 0x0100_0020 … 0x011F_1F20;
  - NOP word 0x00000000.
  - Then `fir_clr` pulses once, `done` pulses at cycle 136 after `start`, and `busy` is high for 135 cycles.
- Backpressure: drop `coeff_valid` for 7 cycles before tap 5 → LOAD holds with `coeff_ready`=1, no write is issued, the stored index sequence is unchanged, and total length is 142 cycles.
- Spurious start: pulse `start` during a load → no extra CLR, exactly one `done`.
- Async reset during tap 10 GAP → outputs go to reset values without waiting for a clock edge. A following `start` rewrites CLR then taps 0..31.
- `ext_stall` toggling in IDLE and during a load → `fir_stall` equals `ext_stall` in IDLE and stays 1 throughout the load.
